// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared types for the instruction fetch stage.
//   redir_sel_t  : which redirect source won arbitration this cycle
//   q_state_t    : occupancy state of the fetch queue
//   entry_t      : default-width queue entry {instr, pc}; the top level
//                  rebuilds the same layout at its own parameter widths
//   q_state_of() : maps an occupancy count onto q_state_t
package fetch_pkg;

    typedef enum logic [1:0] {
        REDIR_NONE,
        REDIR_BR,
        REDIR_J,
        REDIR_JR
    } redir_sel_t;

    typedef enum logic [1:0] {
        Q_EMPTY,
        Q_FILLING,
        Q_FULL
    } q_state_t;

    localparam int unsigned DEFAULT_ADDR_WIDTH  = 32;
    localparam int unsigned DEFAULT_INSTR_WIDTH = 32;

    typedef struct packed {
        logic [DEFAULT_INSTR_WIDTH-1:0] instr;
        logic [DEFAULT_ADDR_WIDTH-1:0]  pc;
    } entry_t;

    function automatic q_state_t q_state_of(input int unsigned cnt,
                                            input int unsigned depth);
        if (cnt == 0)
            return Q_EMPTY;
        else if (cnt >= depth)
            return Q_FULL;
        else
            return Q_FILLING;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue
// Circular FIFO holding fetched {instr, pc} entries for decode.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : drop all entries at the next edge (wins over enq/deq)
//   enq/enq_data: push one entry
//   deq         : pop the head (ignored when empty)
//   count       : number of stored entries, 0..DEPTH
//   state       : Q_EMPTY / Q_FILLING / Q_FULL, tracks count
//   head        : entry at the read pointer
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter type         elem_t = fetch_pkg::entry_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   enq,
    input  elem_t                  enq_data,
    input  logic                   deq,
    output logic [$clog2(DEPTH):0] count,
    output q_state_t               state,
    output elem_t                  head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    elem_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_next;
    q_state_t         state_q;
    logic             do_enq;
    logic             do_deq;

    assign do_enq = enq & ~flush;
    assign do_deq = deq & ~flush & (count_q != '0);

    always_comb begin
        count_next = count_q;
        if (flush)
            count_next = '0;
        else if (do_enq && !do_deq)
            count_next = count_q + 1'b1;
        else if (do_deq && !do_enq)
            count_next = count_q - 1'b1;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            state_q <= Q_EMPTY;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            state_q <= Q_EMPTY;
        end else begin
            if (do_enq)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_deq)
                rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_next;
            state_q <= q_state_of(32'(count_next), DEPTH);
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq)
            mem[wr_ptr] <= enq_data;
    end

    assign head  = mem[rd_ptr];
    assign count = count_q;
    assign state = state_q;

    // The fetch credit rule should make this unreachable.
    no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(do_enq && state_q == Q_FULL));

endmodule

// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue
// Fetch stage: owns the fetch PC, issues one read per cycle to a synchronous
// 1-cycle instruction memory, and buffers returned words for decode.
// Ports:
//   Clk, Reset            : clock, asynchronous active-low reset
//   BranchTaken/Target    : redirect (lowest priority)
//   Jump/JumpTarget       : redirect (middle priority)
//   JumpRegister/...Target: redirect (highest priority)
//   imem_req, imem_addr   : read request and address
//   imem_rdata            : read data, valid the cycle after a request
//   out_valid, out_ready  : decode handshake
//   instr_out, instr_pc   : head instruction and its address
//   pc_out                : instr_pc + PC_STEP
module instruction_fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           INSTR_WIDTH = 32,
    parameter int unsigned           QUEUE_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int unsigned           PC_STEP     = 4
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   BranchTaken,
    input  logic [ADDR_WIDTH-1:0]  BranchTarget,
    input  logic                   Jump,
    input  logic [ADDR_WIDTH-1:0]  JumpTarget,
    input  logic                   JumpRegister,
    input  logic [ADDR_WIDTH-1:0]  JumpRegisterTarget,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    output logic [ADDR_WIDTH-1:0]  pc_out
);

    localparam int unsigned           CNT_W = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(PC_STEP);

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0]  pc;
    } fetch_entry_t;

    redir_sel_t            redir_sel;
    logic                  redirect;
    logic [ADDR_WIDTH-1:0] redir_target;

    logic [ADDR_WIDTH-1:0] fpc;
    logic [ADDR_WIDTH-1:0] rsp_pc;
    logic                  inflight;
    logic                  kill;
    logic                  issue;
    logic [CNT_W:0]        occupancy;

    logic [CNT_W-1:0]      q_count;
    q_state_t              q_state;
    fetch_entry_t          q_head;
    fetch_entry_t          rsp_entry;
    logic                  rsp_enq;
    logic                  transfer;

    // Redirect arbitration: JumpRegister > Jump > BranchTaken.
    always_comb begin
        redir_sel = REDIR_NONE;
        if (JumpRegister)
            redir_sel = REDIR_JR;
        else if (Jump)
            redir_sel = REDIR_J;
        else if (BranchTaken)
            redir_sel = REDIR_BR;
    end

    always_comb begin
        redir_target = '0;
        case (redir_sel)
            REDIR_JR: redir_target = JumpRegisterTarget;
            REDIR_J:  redir_target = JumpTarget;
            REDIR_BR: redir_target = BranchTarget;
            default:  redir_target = '0;
        endcase
    end

    assign redirect = (redir_sel != REDIR_NONE);

    // Credit counts the outstanding response as occupied so a full queue
    // can never receive a word it has no room for.
    assign occupancy = {1'b0, q_count} + {{CNT_W{1'b0}}, inflight};
    assign issue     = Reset & ~redirect
                     & (occupancy < (CNT_W + 1)'(QUEUE_DEPTH));

    assign imem_req  = issue;
    assign imem_addr = fpc;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            fpc      <= RESET_PC;
            rsp_pc   <= '0;
            inflight <= 1'b0;
            kill     <= 1'b0;
        end else begin
            inflight <= issue;
            kill     <= redirect;
            if (issue)
                rsp_pc <= fpc;
            if (redirect)
                fpc <= redir_target;
            else if (issue)
                fpc <= fpc + STEP;
        end
    end

    // A redirect in the response cycle drops the word directly; kill covers
    // a redirect that landed in the issue-to-response window one cycle back.
    assign rsp_enq   = inflight & ~kill & ~redirect;
    assign rsp_entry = '{instr: imem_rdata, pc: rsp_pc};

    assign out_valid = (q_state != Q_EMPTY) & ~redirect;
    assign transfer  = out_valid & out_ready;

    fetch_queue #(
        .DEPTH  (QUEUE_DEPTH),
        .elem_t (fetch_entry_t)
    ) u_queue (
        .clk      (Clk),
        .rst_n    (Reset),
        .flush    (redirect),
        .enq      (rsp_enq),
        .enq_data (rsp_entry),
        .deq      (transfer),
        .count    (q_count),
        .state    (q_state),
        .head     (q_head)
    );

    // Head fields are zeroed while invalid so reset presents all-zero outputs.
    assign instr_out = out_valid ? q_head.instr       : '0;
    assign instr_pc  = out_valid ? q_head.pc          : '0;
    assign pc_out    = out_valid ? (q_head.pc + STEP) : '0;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// tb_instruction_fetch_queue
// Directed bench for instruction_fetch_queue with a 1-cycle memory model
// returning a fixed function of the address.
module tb_instruction_fetch_queue;

    logic        clk = 1'b0;
    logic        Reset;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic        JumpRegister;
    logic [31:0] JumpRegisterTarget;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic [31:0] pc_out;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    instruction_fetch_queue #(
        .ADDR_WIDTH  (32),
        .INSTR_WIDTH (32),
        .QUEUE_DEPTH (4),
        .RESET_PC    (32'h0000_0000),
        .PC_STEP     (4)
    ) dut (
        .Clk                (clk),
        .Reset              (Reset),
        .BranchTaken        (BranchTaken),
        .BranchTarget       (BranchTarget),
        .Jump               (Jump),
        .JumpTarget         (JumpTarget),
        .JumpRegister       (JumpRegister),
        .JumpRegisterTarget (JumpRegisterTarget),
        .imem_req           (imem_req),
        .imem_addr          (imem_addr),
        .imem_rdata         (imem_rdata),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .instr_out          (instr_out),
        .instr_pc           (instr_pc),
        .pc_out             (pc_out)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {2'b00, a[31:2]} ^ 32'h5A00_0000;
    endfunction

    always @(posedge clk) begin
        if (imem_req)
            imem_rdata <= word_at(imem_addr);
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        Reset = 1'b0; out_ready = 1'b1;
        BranchTaken = 1'b0; BranchTarget = '0;
        Jump = 1'b0; JumpTarget = '0;
        JumpRegister = 1'b0; JumpRegisterTarget = '0;

        // Reset values
        tick(); tick(); #1;
        check("rst_valid", out_valid, 0);
        check("rst_req", imem_req, 0);
        check("rst_instr", instr_out, 0);
        check("rst_pc", instr_pc, 0);
        check("rst_pcout", pc_out, 0);

        // Stream from RESET_PC
        tick(); Reset = 1'b1; #1;
        check("c1_req", imem_req, 1);
        check("c1_addr", imem_addr, 32'h0);
        tick(); #1;
        check("c2_valid", out_valid, 0);
        check("c2_addr", imem_addr, 32'h4);
        for (int k = 0; k < 6; k++) begin
            tick(); #1;
            check("stream_valid", out_valid, 1);
            check("stream_pc", instr_pc, 32'(4 * k));
            check("stream_instr", instr_out, word_at(32'(4 * k)));
            check("stream_pcout", pc_out, 32'(4 * k + 4));
        end

        // Back-pressure: head 0x18 held for 10 cycles, requests stop at fill
        for (int i = 0; i < 10; i++) begin
            tick(); out_ready = 1'b0; #1;
            check("bp_valid", out_valid, 1);
            check("bp_pc", instr_pc, 32'h18);
            check("bp_req", imem_req, (i < 2) ? 1 : 0);
            if (i == 0) check("bp_addr0", imem_addr, 32'h20);
        end
        for (int i = 0; i < 10; i++) begin
            tick(); out_ready = 1'b1; #1;
            check("rel_valid", out_valid, 1);
            check("rel_pc", instr_pc, 32'(32'h18 + 4 * i));
            if (i == 0) check("rel_req0", imem_req, 0);
            if (i == 1) begin
                check("rel_req1", imem_req, 1);
                check("rel_addr1", imem_addr, 32'h28);
            end
        end

        // Priority: all three redirects at once
        tick();
        BranchTaken = 1'b1; BranchTarget = 32'h100;
        Jump = 1'b1; JumpTarget = 32'h200;
        JumpRegister = 1'b1; JumpRegisterTarget = 32'h300;
        #1;
        check("pri_valid", out_valid, 0);
        check("pri_req", imem_req, 0);
        tick(); BranchTaken = 1'b0; Jump = 1'b0; JumpRegister = 1'b0; #1;
        check("pri_addr", imem_addr, 32'h300);
        check("pri_req1", imem_req, 1);
        check("pri_flushed", out_valid, 0);
        tick(); #1;
        check("pri_valid2", out_valid, 0);
        check("pri_addr2", imem_addr, 32'h304);
        tick(); #1;
        check("pri_valid3", out_valid, 1);
        check("pri_pc3", instr_pc, 32'h300);
        check("pri_instr3", instr_out, word_at(32'h300));
        tick(); #1;
        check("pri_pc4", instr_pc, 32'h304);

        // Kill in flight: redirect in the response cycle of 0x10
        tick(); Jump = 1'b1; JumpTarget = 32'h10; #1;
        check("kill_jvalid", out_valid, 0);
        tick(); Jump = 1'b0; #1;
        check("kill_req10", imem_req, 1);
        check("kill_addr10", imem_addr, 32'h10);
        tick(); BranchTaken = 1'b1; BranchTarget = 32'h40; #1;
        check("kill_bvalid", out_valid, 0);
        check("kill_breq", imem_req, 0);
        tick(); BranchTaken = 1'b0; #1;
        check("kill_addr40", imem_addr, 32'h40);
        check("kill_valid1", out_valid, 0);
        tick(); #1;
        check("kill_valid2", out_valid, 0);
        tick(); #1;
        check("kill_valid3", out_valid, 1);
        check("kill_pc40", instr_pc, 32'h40);
        tick(); #1;
        check("kill_pc44", instr_pc, 32'h44);

        // Address wrap
        tick(); JumpRegister = 1'b1; JumpRegisterTarget = 32'hFFFF_FFF8; #1;
        tick(); JumpRegister = 1'b0; #1;
        check("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
        tick(); #1;
        check("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
        tick(); #1;
        check("wrap_addr2", imem_addr, 32'h0);
        check("wrap_pc0", instr_pc, 32'hFFFF_FFF8);
        check("wrap_pcout0", pc_out, 32'hFFFF_FFFC);
        tick(); #1;
        check("wrap_pc1", instr_pc, 32'hFFFF_FFFC);
        check("wrap_pcout1", pc_out, 32'h0);
        tick(); #1;
        check("wrap_pc2", instr_pc, 32'h0);
        check("wrap_instr2", instr_out, word_at(32'h0));

        // Mid-operation reset with count=3, inflight=1
        tick(); out_ready = 1'b0; #1;
        check("mr_pc", instr_pc, 32'h4);
        tick(); #1;
        check("mr_req", imem_req, 1);
        tick(); #1;
        check("mr_full_req", imem_req, 0);
        check("mr_valid", out_valid, 1);
        #1; Reset = 1'b0; #1;
        check("mr_valid_rst", out_valid, 0);
        check("mr_req_rst", imem_req, 0);
        check("mr_pc_rst", instr_pc, 0);
        check("mr_pcout_rst", pc_out, 0);
        tick(); #1;
        check("mr_valid_hold", out_valid, 0);
        tick(); Reset = 1'b1; out_ready = 1'b1; #1;
        check("mr_req1", imem_req, 1);
        check("mr_addr1", imem_addr, 32'h0);
        check("mr_valid1", out_valid, 0);
        tick(); #1;
        check("mr_valid2", out_valid, 0);
        tick(); #1;
        check("mr_valid3", out_valid, 1);
        check("mr_pc3", instr_pc, 32'h0);
        check("mr_instr3", instr_out, word_at(32'h0));
        tick(); #1;
        check("mr_pc4", instr_pc, 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_queue.md
# instruction_fetch_queue

Parametrised fetch stage for the pipelined datapath. Keeps the PC, issues one instruction-memory read per cycle to a synchronous memory with fixed 1-cycle latency, and buffers the returned instructions in a small queue. The queue feeds decode over a valid/ready handshake. Redirects (branch, j, jr) flush all younger work, so decode stalls no longer freeze the PC directly.

## Interface
Parameters:
- ADDR_WIDTH, 32, PC and memory address width
- INSTR_WIDTH, 32, instruction word width
- QUEUE_DEPTH, 4, fetch queue entries; power of two, ≥2
- RESET_PC, 0, PC value after reset
- PC_STEP, 4, sequential PC increment

Ports:
- Clk  in  1  clock; all state changes on the rising edge
- Reset  in  1  asynchronous, active-low reset
- BranchTaken  in  1  redirect to BranchTarget
- BranchTarget  in  ADDR_WIDTH  branch target
- Jump  in  1  redirect to JumpTarget
- JumpTarget  in  ADDR_WIDTH  j target
- JumpRegister  in  1  redirect to JumpRegisterTarget
- JumpRegisterTarget  in  ADDR_WIDTH  jr target
- imem_req  out  1  read request this cycle
- imem_addr  out  ADDR_WIDTH  read address
- imem_rdata  in  INSTR_WIDTH  read data; valid the cycle after a request
- out_valid  out  1  queue head is presentable to decode
- out_ready  in  1  decode accepts the head
- instr_out  out  INSTR_WIDTH  head instruction
- instr_pc  out  ADDR_WIDTH  head instruction address
- pc_out  out  ADDR_WIDTH  instr_pc + PC_STEP

## Operation
- **Redirect priority:** JumpRegister > Jump > BranchTaken. Any one of these asserted is a redirect.
- **Fetch PC register (fpc):**
  - On a redirect, fpc loads the selected target.
  - On an issued request, fpc loads fpc + PC_STEP, modulo 2^ADDR_WIDTH. The wrap from all-ones goes to 0 with no flag.
- **Issue rule:** imem_req = ~redirect & (count + inflight < QUEUE_DEPTH).
  - imem_addr = fpc.
  - inflight is a 1-bit register set on issue, cleared otherwise.
- **Response:**
  - If inflight=1 and the request was not killed, {imem_rdata, its address} is enqueued at the end of the response cycle.
  - A redirect in the response cycle, or in the cycle after the issue, kills the response. This is tracked with a kill flag.
- **Queue:** circular buffer with a count of 0..QUEUE_DEPTH.
  - Head fields drive instr_out and instr_pc.
  - Enqueue and dequeue may happen in the same cycle.
  - The credit rule makes overflow impossible. Enqueue-when-full is an assertion failure.
- **Handshake:**
  - out_valid = (count≠0) & ~redirect.
  - A transfer happens when out_valid & out_ready; it dequeues the head.
  - If out_ready=0, the head and its fields hold stable.
- **Redirect:**
  - Clears count and pointers at the edge.
  - Kills any in-flight response.
  - No transfer occurs in the redirect cycle.
- **Control states:** EMPTY (count=0), FILLING (0<count<DEPTH), FULL (count=DEPTH). Transitions follow the count. A redirect from any state goes to EMPTY.

## Timing
- **Reset values (asserted, asynchronous):**
  - fpc = RESET_PC; count, pointers, inflight and kill = 0.
  - out_valid = 0, imem_req = 0.
  - instr_out, instr_pc and pc_out = 0. These are don't-care while invalid, but must be 0 in reset.
- **After reset:**
  - The first request issues in the first cycle after deassertion, with imem_addr = RESET_PC.
  - The first out_valid comes 2 cycles later.
- **Latency:**
  - Request issued in cycle t → data arrives in t+1 → out_valid in t+2.
  - Redirect in cycle r → request at the target in r+1 → out_valid in r+3.
- **Throughput:** one instruction per cycle in steady state with out_ready=1 (count=1, inflight=1).
- **Stall:**
  - With out_ready held at 0, the queue fills to QUEUE_DEPTH and imem_req drops.
  - Requests resume the cycle after the first dequeue frees a credit.
- **Simultaneous events:**
  - Redirect + out_ready=1: no transfer.
  - Redirect + response: the response is discarded.
  - Reset mid-operation: immediate return to reset values; the in-flight response is never enqueued.

## Structure
- **fetch_pkg:**
  - redirect select enum {REDIR_NONE, REDIR_BR, REDIR_J, REDIR_JR}
  - queue state enum {Q_EMPTY, Q_FILLING, Q_FULL}
  - entry struct {instr, pc}
- **Sub-module fetch_queue:** parametrised circular FIFO with flush, enqueue, dequeue, count and head outputs.
- **Top level holds:** fpc, redirect mux, credit logic, and inflight/kill tracking.

## Test plan
- **Reset and stream:** RESET_PC=0x0, memory holds word i at address 4i, out_ready=1 → instr_pc 0x0, 0x4, 0x8… on consecutive cycles, first valid 2 cycles after reset release; pc_out = instr_pc + 4.
- **Back-pressure:** out_ready=0 for 10 cycles → count saturates at 4, imem_req=0 after the fill. On release: 4 in-order transfers, then a gapless stream with no lost or duplicated PCs.
- **Priority:** assert BranchTaken(0x100), Jump(0x200) and JumpRegister(0x300) in the same cycle → next imem_addr = 0x300, queue flushed, next delivered instr_pc = 0x300 at r+3.
- **Kill in flight:** BranchTaken(0x40) the cycle after the request for 0x10 issues → 0x10 is never delivered; the next delivered PC is 0x40.
- **Wrap:** RESET_PC = 0xFFFF_FFF8 → delivered PCs are FFFF_FFF8, FFFF_FFFC, 0000_0000.
- **Mid-operation reset:** assert Reset with count=3 and inflight=1 → out_valid=0 immediately; after release, the stream restarts at RESET_PC with no stale entry.
